// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared constants and types for the prefetching fetch unit.
// Imported by ifu_fifo and ifu_prefetch.
package ifu_prefetch_pkg;

  localparam int unsigned IFU_XLEN  = 32;
  localparam int unsigned IFU_DEPTH = 4;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // ID register action for the current cycle
  typedef enum logic [2:0] {
    ID_HOLD,
    ID_FLUSH,
    ID_LOAD,
    ID_BYPASS,
    ID_BUBBLE
  } id_op_e;

  // Width of a counter able to hold 0..d inclusive
  function automatic int unsigned cnt_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with extra-MSB pointer wrap.
// Used for the prefetch buffer and the in-flight address queue.
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer advance, with clear collapsing the queue to empty
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: credit-limited sequential fetch, prefetch FIFO, ID register.
// Define IFU_RSP_BYPASS_EN to let a response load ID directly when idle.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter int unsigned     DEPTH    = IFU_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_addr
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned SW = CW + 2;
  localparam logic [XLEN-1:0] NOP = XLEN'(INST_NOP);

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_rdata;
  logic              aq_full;
  logic              aq_empty;
  logic [XLEN-1:0]   aq_head;
  logic [SW-1:0]     credit_used;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_take;
  logic              byp_hit;
  logic              can_adv;
  id_op_e            id_op;

  assign credit_used = SW'(fifo_count) + SW'(outstanding) + SW'(drop);

  assign imem_req_valid = !flush && (credit_used < SW'(DEPTH));
  assign imem_req_addr  = pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_take = imem_rsp_valid && (drop == '0) && !flush;
  assign can_adv  = !flush && !stall;

`ifdef IFU_RSP_BYPASS_EN
  assign byp_hit = fifo_empty && rsp_take;
`else
  assign byp_hit = 1'b0;
`endif

  assign fifo_push = rsp_take && (id_op != ID_BYPASS);
  assign fifo_pop  = (id_op == ID_LOAD);

  // The address queue occupancy is the outstanding-fetch count
  ifu_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (req_fire),
    .pop   (rsp_take),
    .clear (flush),
    .wdata (pc),
    .rdata (aq_head),
    .full  (aq_full),
    .empty (aq_empty),
    .count (outstanding)
  );

  ifu_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_pf_q (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush),
    .wdata ({aq_head, imem_rsp_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch pointer: redirect wins, otherwise step on each accepted request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= flush_addr;
    end else if (req_fire) begin
      pc <= pc + XLEN'(4);
    end
  end

  // Squashed fetches still owed by memory; their responses are discarded
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop <= '0;
    end else if (flush) begin
      drop <= drop + outstanding - CW'(imem_rsp_valid);
    end else if (rsp_drop) begin
      drop <= drop - CW'(1);
    end
  end

  // Choose the ID register action; terms are made mutually exclusive
  always_comb begin
    id_op = ID_BUBBLE;
    unique case (1'b1)
      flush:                    id_op = ID_FLUSH;
      (stall && !flush):        id_op = ID_HOLD;
      (can_adv && !fifo_empty): id_op = ID_LOAD;
      (can_adv && byp_hit):     id_op = ID_BYPASS;
      default:                  id_op = ID_BUBBLE;
    endcase
  end

  // ID register: the registered instruction presented to decode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_addr  <= '0;
    end else begin
      unique case (id_op)
        ID_FLUSH: begin
          id_valid <= 1'b0;
          id_inst  <= NOP;
        end
        ID_HOLD: begin
          id_valid <= id_valid;
        end
        ID_LOAD: begin
          id_valid <= 1'b1;
          id_inst  <= fifo_rdata[XLEN-1:0];
          id_addr  <= fifo_rdata[2*XLEN-1:XLEN];
        end
        ID_BYPASS: begin
          id_valid <= 1'b1;
          id_inst  <= imem_rsp_data;
          id_addr  <= aq_head;
        end
        default: begin
          id_valid <= 1'b0;
          id_inst  <= NOP;
        end
      endcase
    end
  end

  // Credit accounting must make these impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_push && fifo_full));
  a_aq_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(req_fire && aq_full));
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rstn)
    !(rsp_take && aq_empty));

endmodule
